// File: rtl/gen_arb_pkg.sv
// Shared types and helpers for the generic round-robin arbiter.
// The FSM encoding and the one-hot to binary index conversion live here.
package gen_arb_pkg;

    localparam int unsigned ARB_DEF_WID = 16;
    // Upper bound on client count accepted by onehot2idx.
    localparam int unsigned ARB_MAX_WID = 256;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } arb_st_t;

    function automatic int unsigned onehot2idx(input logic [ARB_MAX_WID-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < ARB_MAX_WID; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/gen_arb_first_one.sv
// Lowest-set-bit selector: one-hot of the lowest asserted request plus an
// any-request flag. Purely combinational.
module gen_arb_first_one
    import gen_arb_pkg::*;
#(
    parameter int unsigned WID = ARB_DEF_WID
) (
    input  logic [WID-1:0] req_i,
    output logic [WID-1:0] gnt_o,
    output logic           any_o
);

    // Two's-complement trick isolates the lowest set bit.
    always_comb begin
        gnt_o = req_i & (~req_i + WID'(1));
        any_o = |req_i;
    end

endmodule

// File: rtl/gen_arb_rr_grnt_ctrl.sv
// Round-robin grant controller: registered one-hot grants with a rotating
// priority mask and a per-grant hold limit.
module gen_arb_rr_grnt_ctrl
    import gen_arb_pkg::*;
#(
    parameter int unsigned WID      = ARB_DEF_WID,
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned IDX_W    = $clog2(WID)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WID-1:0]   rqsts,
    output logic [WID-1:0]   grnts,
    output logic             grnt_vld,
    output logic [IDX_W-1:0] grnt_idx,
    output logic [WID-1:0]   mask
);

    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    arb_st_t           state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [WID-1:0]    grnts_q, grnts_d;
    logic              vld_q, vld_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WID-1:0]    mask_q, mask_d;

    logic [WID-1:0]    m_rq;
    logic [WID-1:0]    m_oh, u_oh;
    logic              m_any, u_any;
    logic [WID-1:0]    win_oh;
    logic [IDX_W-1:0]  win_idx;
    logic [WID-1:0]    win_pre;
    logic [WID-1:0]    mask_nx;
    logic              grant_end;
    logic              issue;

    assign m_rq = rqsts & mask_q;

    gen_arb_first_one #(.WID(WID)) u_first_masked (
        .req_i (m_rq),
        .gnt_o (m_oh),
        .any_o (m_any)
    );

    gen_arb_first_one #(.WID(WID)) u_first_unmasked (
        .req_i (rqsts),
        .gnt_o (u_oh),
        .any_o (u_any)
    );

    // Masked winner takes precedence; the unmasked path provides wrap-around.
    always_comb begin
        win_oh  = m_any ? m_oh : u_oh;
        win_idx = IDX_W'(onehot2idx(ARB_MAX_WID'(win_oh)));
    end

    // Next mask: every client strictly above the winner.
    always_comb begin
        win_pre    = '0;
        win_pre[0] = win_oh[0];
        for (int unsigned i = 1; i < WID; i++) begin
            win_pre[i] = win_pre[i-1] | win_oh[i];
        end
        mask_nx = win_pre << 1;
    end

    always_comb begin
        grant_end = (state_q == ST_GRANT) &&
                    (!rqsts[idx_q] || (hold_q == HOLD_W'(MAX_HOLD - 1)));
        issue     = ((state_q == ST_IDLE) || grant_end) && u_any;
    end

    // FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (u_any) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (grant_end && !u_any) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: output/datapath next values.
    always_comb begin
        hold_d  = hold_q;
        grnts_d = grnts_q;
        vld_d   = vld_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        if (issue) begin
            hold_d  = '0;
            grnts_d = win_oh;
            vld_d   = 1'b1;
            idx_d   = win_idx;
            mask_d  = mask_nx;
        end else if (grant_end) begin
            hold_d  = '0;
            grnts_d = '0;
            vld_d   = 1'b0;
        end else if (state_q == ST_GRANT) begin
            hold_d  = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            grnts_q <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
            mask_q  <= '0;
        end else begin
            hold_q  <= hold_d;
            grnts_q <= grnts_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
        end
    end

    assign grnts    = grnts_q;
    assign grnt_vld = vld_q;
    assign grnt_idx = idx_q;
    assign mask     = mask_q;

endmodule

// File: tb/tb_gen_arb_rr_grnt_ctrl.sv
// Scoreboard bench: two 4-client controllers (hold limits 4 and 1) share the
// request bus and are checked against a pointer-based round-robin model.
module tb_gen_arb_rr_grnt_ctrl;

    localparam int NC = 4;

    logic          clk;
    logic          rst_n;
    logic [NC-1:0] rqsts;
    logic [NC-1:0] g0, g1, m0, m1;
    logic          v0, v1;
    logic [1:0]    i0, i1;

    gen_arb_rr_grnt_ctrl #(.WID(NC), .MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rqsts    (rqsts),
        .grnts    (g0),
        .grnt_vld (v0),
        .grnt_idx (i0),
        .mask     (m0)
    );

    gen_arb_rr_grnt_ctrl #(.WID(NC), .MAX_HOLD(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .rqsts    (rqsts),
        .grnts    (g1),
        .grnt_vld (v1),
        .grnt_idx (i1),
        .mask     (m1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  g0, m0, g1, m1;
        logic [1:0]  i0, i1;
        logic        v0, v1;
    } exp_t;

    exp_t q[$];
    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: owner (-1 = none), cycles held, last winner pointer.
    int         owner[2];
    int         held[2];
    int         ptr[2];
    logic [1:0] eidx[2];
    int         mh[2] = '{4, 1};

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1;
            held[k]  = 0;
            ptr[k]   = NC - 1;
            eidx[k]  = 2'd0;
        end
    endfunction

    function automatic void model_step(input int k, input logic [3:0] rq);
        int w;
        bit ending;
        ending = (owner[k] < 0) || !rq[owner[k]] || (held[k] == mh[k] - 1);
        if (!ending) begin
            held[k]++;
        end else begin
            w = -1;
            for (int s = 1; s <= NC; s++) begin
                int c;
                c = (ptr[k] + s) % NC;
                if (w < 0 && rq[c]) w = c;
            end
            owner[k] = w;
            held[k]  = 0;
            if (w >= 0) begin
                ptr[k]  = w;
                eidx[k] = 2'(w);
            end
        end
    endfunction

    function automatic logic [3:0] exp_grnt(input int k);
        logic [3:0] g;
        g = '0;
        if (owner[k] >= 0) g[owner[k]] = 1'b1;
        return g;
    endfunction

    function automatic logic [3:0] exp_mask(input int k);
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < NC; i++) if (i > ptr[k]) m[i] = 1'b1;
        return m;
    endfunction

    // Called at posedge+1: drive requests, predict the next edge, advance a cycle.
    task automatic step(input logic [3:0] rq);
        exp_t e;
        rqsts = rq;
        model_step(0, rq);
        model_step(1, rq);
        e.cyc = cyc + 1;
        e.g0 = exp_grnt(0); e.m0 = exp_mask(0); e.i0 = eidx[0]; e.v0 = (owner[0] >= 0);
        e.g1 = exp_grnt(1); e.m1 = exp_mask(1); e.i1 = eidx[1]; e.v1 = (owner[1] >= 0);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("h4_grnts", g0, e.g0);
            chk("h4_mask",  m0, e.m0);
            chk("h4_idx",   {2'b00, i0}, {2'b00, e.i0});
            chk("h4_vld",   {3'b000, v0}, {3'b000, e.v0});
            chk("h1_grnts", g1, e.g1);
            chk("h1_mask",  m1, e.m1);
            chk("h1_idx",   {2'b00, i1}, {2'b00, e.i1});
            chk("h1_vld",   {3'b000, v1}, {3'b000, e.v1});
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grnts"}, g0, 4'b0000);
        chk({tag, "_vld"},   {3'b000, v0}, 4'b0000);
        chk({tag, "_mask"},  m0, 4'b0000);
        chk({tag, "_grnts1"}, g1, 4'b0000);
        chk({tag, "_mask1"},  m1, 4'b0000);
    endtask

    logic [3:0] rq_r;

    initial begin
        rst_n = 1'b0;
        rqsts = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        chk_reset_outputs("reset");
        chk("reset_idx", {2'b00, i0}, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (5)  step(4'b0000);
        repeat (20) step(4'b1111);
        repeat (10) step(4'b0100);
        repeat (5)  step(4'b0000);
        repeat (6)  step(4'b0011);
        repeat (4)  step(4'b0001);

        // Mid-grant asynchronous reset, between clock edges.
        step(4'b1111);
        step(4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4)  step(4'b1000);

        repeat (10) step(4'b0101);

        rq_r = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < NC; b++) begin
                if ($urandom_range(0, 5) == 0) rq_r[b] = ~rq_r[b];
            end
            step(rq_r);
        end
        step(4'b0000);

        repeat (2) @(negedge clk);
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gen_arb_rr_grnt_ctrl.md
# gen_arb_rr_grnt_ctrl

Round-robin grant controller that turns a raw request bus into registered one-hot grants. It owns the rotating priority mask and the grant hold counter. It sits between the client request lines and the shared resource's select logic. It is the grant-issuing end of the arbiter: it consumes `rqsts` and produces `grnts`, plus the next-cycle mask it derives from those grants.

## Interface
- `WID`, 16: number of clients; width of `rqsts` and `grnts`. Legal range is ≥2.
- `MAX_HOLD`, 4: maximum consecutive cycles one client may hold a grant. Legal range is ≥1.
- `IDX_W`, `$clog2(WID)`: width of `grnt_idx`. Derived; not overridden.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `rqsts` input WID: level request per client. Client i holds `rqsts[i]` high for as long as it wants the resource.
- `grnts` output WID: registered grant, one-hot or zero.
- `grnt_vld` output 1: registered; equals `|grnts`.
- `grnt_idx` output IDX_W: registered binary index of the granted client. Holds its last value when `grnt_vld`=0.
- `mask` output WID: registered priority mask. Bit i set means client i is in the high-priority (masked) set.

## Operation
- Two states:
  - IDLE: no grant.
  - GRANT: one client granted; `hold_cnt` counts the cycles the grant has been held.
- Arbitration, evaluated combinationally every cycle on current `rqsts` and registered `mask`:
  - `m_rq = rqsts & mask`.
  - If `m_rq` is non-zero, the winner is the lowest set bit of `m_rq`.
  - Otherwise, the winner is the lowest set bit of `rqsts`.
  - If no request is set, there is no winner.
- Grant ends in a cycle when either:
  - `rqsts[grnt_idx]`=0 (release), or
  - `hold_cnt`==MAX_HOLD-1 (expiry).
- IDLE:
  - Winner present → GRANT next cycle, with `grnts`=onehot(winner) and `hold_cnt`=0.
  - No winner → remain in IDLE.
- GRANT, grant not ending: keep `grnts`, `hold_cnt`++.
- GRANT, grant ending:
  - Winner present → new grant next cycle, no bubble, `hold_cnt`=0.
  - No winner → IDLE, `grnts`=0.
- Arbitration at end of grant uses the `mask` already updated for the ending grant. The ending client is therefore lowest priority.
- On expiry with the ending client as sole requester, it wins again through the unmasked path: re-granted with `hold_cnt`=0.
- Mask update: on every cycle a new grant is issued (including a re-grant), `mask` ← bits strictly above the winner's index. Example: winner 2, WID=4 → 4'b1000. Winner WID-1 → all zeros.
- `mask` is unchanged in cycles where no new grant is issued.
- A request dropped and re-raised by a non-granted client has no effect on its priority.
- `hold_cnt` width is `$clog2(MAX_HOLD)`, minimum 1 bit, and never exceeds MAX_HOLD-1.
- MAX_HOLD=1 gives a single-cycle grant, rotating every cycle while there are multiple requesters.

## Timing
- Reset (async assert, sync deassert by the system):
  - `grnts`=0, `grnt_vld`=0, `grnt_idx`=0, `mask`=0.
  - `hold_cnt`=0, state IDLE.
- Reset asserted mid-grant clears the grant immediately (asynchronously). No state is retained.
- Latency: request sampled at edge N → `grnts` at edge N+1, from IDLE or at a handover.
- Release in cycle N → `grnts[old]`=0 from edge N+1. The new grant, if any, is visible from the same edge.
- Max continuous ownership is MAX_HOLD cycles, unless the owner is the only requester.
- Starvation bound: every persistent requester is granted within (WID-1)·MAX_HOLD+1 cycles.
- All outputs are flops; no combinational path from `rqsts` to any output.

## Structure
- Shared package `gen_arb_pkg`:
  - typedef `arb_st_t` {ST_IDLE, ST_GRANT}.
  - Function `onehot2idx`.
  - Constant `ARB_DEF_WID`=16.
- Sub-module `gen_arb_first_one` (parameter WID): combinational lowest-set-bit one-hot selector plus `any` flag. Instantiated twice: masked path and unmasked path.
- Top level contains:
  - Winner mux.
  - Mask-next computation: prefix-OR of the winner one-hot, shifted left by one.
  - State/hold counter.
  - Output registers.

## Test plan
- WID=4, MAX_HOLD=4, reset then `rqsts`=4'b0000 for 5 cycles → `grnts`=0, `grnt_vld`=0, `mask`=0 throughout.
- `rqsts`=4'b1111 held constant → grants 0,1,2,3,0…, each held for exactly 4 cycles. Edges are back-to-back with no idle cycle. `mask` steps 1110, 1100, 1000, 0000.
- `rqsts`=4'b0100 for 10 cycles → client 2 granted from cycle 1. It is re-granted at each expiry with `hold_cnt` reset and `mask`=4'b1000, and `grnts` never drops.
- Client 1 is granted; `rqsts` goes from 4'b0011 to 4'b0001 in cycle N → from N+1, `grnts`=4'b0001 and `mask`=4'b1110 (wrap-around through the unmasked path).
- Assert `rst_n`=0 mid-grant between clock edges → `grnts`, `grnt_vld`, and `mask` are 0 immediately. After deassert with `rqsts`=4'b1000, client 3 is granted one edge later.
- MAX_HOLD=1, `rqsts`=4'b0101 → `grnts` alternates 0001/0100 every cycle.
